dds_phase_bank_axil: RTL
========================

# dds_phase_bank_axil

Multi-channel DDS phase generator with an AXI4-Lite control slave, the parametrised successor to the single-register-bank handmadedds peripheral. It holds NUM_CH phase accumulators, each with a programmable frequency tuning word (FTW) and phase offset. Software writes the FTW and offset values into shadow registers and then commits them to all channels in the same cycle. The block sits between the PS AXI interconnect and the AD9142 sample path, and delivers truncated phase words to the downstream phase-to-amplitude stage at the DAC sample rate.

## Interface
- NUM_CH, 4: number of channels, range 1–8.
- ACC_W, 32: accumulator, FTW and offset width, range OUT_W to 32.
- OUT_W, 16: output phase width per channel.
- C_S_AXI_ADDR_WIDTH, 8: AXI4-Lite address width.
- ACLK  in  1  single clock for AXI and datapath.
- ARESETN  in  1  asynchronous assert, active-low reset.
- s_axi_awaddr/awvalid/awready, s_axi_wdata(32)/wstrb(4)/wvalid/wready, s_axi_bresp(2)/bvalid/bready: AXI4-Lite write channels.
- s_axi_araddr/arvalid/arready, s_axi_rdata(32)/rresp(2)/rvalid/rready: AXI4-Lite read channels.
- sample_en  in  1  advance strobe, one pulse per DAC sample.
- phase_out  out  NUM_CH*OUT_W  channel k occupies bits [k*OUT_W +: OUT_W].
- phase_valid  out  1  registered copy of sample_en gated by global enable.

## Operation
- Register map (byte addresses, 32-bit):
  - 0x00 CTRL: bit0 ENABLE (RW); bit1 COMMIT (W1, self-clearing, reads 0); bit2 ACC_CLR (W1, self-clearing, reads 0).
  - 0x04 STATUS (RO): bit0 COMMIT_PENDING; [11:8] NUM_CH.
  - 0x10+8k FTW_k shadow (RW). 0x14+8k POFF_k shadow (RW). Values are ACC_W LSBs; unused upper bits read 0.
- WSTRB is honoured per byte on every RW register.
- Write handling:
  - Waits for both AWVALID and WVALID, then asserts AWREADY and WREADY together for one cycle.
  - BVALID rises the next cycle and holds until BREADY. Only one write is outstanding.
  - Unmapped address: data discarded, BRESP = SLVERR (2'b10).
- Read handling:
  - ARREADY pulses for one cycle while RVALID is low; RDATA/RVALID follow the next cycle and hold until RREADY.
  - Unmapped address: RDATA = 0, RRESP = SLVERR.
- Commit:
  - A COMMIT write sets COMMIT_PENDING.
  - On the next cycle all active FTW/POFF registers load from the shadows simultaneously and COMMIT_PENDING clears.
  - Shadow writes alone never change the output.
- Accumulator:
  - When ENABLE=1 and sample_en=1: acc_k <= acc_k + FTW_k, modulo 2^ACC_W with natural wrap.
  - phase_out_k <= (acc_k + POFF_k)[ACC_W-1 -: OUT_W], where acc_k is the pre-update value.
- ENABLE=0 freezes the accumulators and phase_out, and holds phase_valid at 0.
- ACC_CLR zeroes all accumulators on the next cycle. If it coincides with COMMIT, both take effect in the same cycle and the first post-clear sample uses the new POFF.
- A simultaneous sample_en and commit updates acc with the old FTW; the new FTW applies from the following sample.

## Timing
- Reset values: all outputs 0, including awready, wready, arready, bvalid, rvalid, rdata, bresp, rresp, phase_out and phase_valid. All registers, shadows and accumulators reset to 0.
- Reset asserted mid-transaction drops all VALID/READY outputs immediately; no response is issued for the aborted transaction.
- Write latency: VALIDs to BVALID is 2 cycles minimum.
- Read latency: ARVALID to RVALID is 2 cycles minimum.
- Commit latency: W handshake cycle, then COMMIT_PENDING visible for one cycle, then the active registers update.
- phase_out and phase_valid are registered, 1 cycle after sample_en.

## Configuration
- DDS_DITHER_EN defined:
  - Adds a shared 16-bit Galois LFSR (taps 16,14,13,11; reset seed 0xACE1, advances on every phase_valid).
  - lfsr[ACC_W-OUT_W-1:0] is added to the discarded LSBs before truncation. Channel k uses the LFSR rotated left by k.
  - STATUS bit1 reads 1.
- DDS_DITHER_EN undefined: plain truncation, no LFSR logic, STATUS bit1 reads 0.

## Test plan
- Write 0x00000001..0x00000004 to 0x10, 0x14, 0x18, 0x1C, then read back -> identical data, OKAY responses; phase_out remains 0 (no commit).
- FTW_0=0x01000000, commit, ENABLE=1, sample_en held high -> channel 0 phase_out steps 0x0000, 0x0100, 0x0200…, wraps to 0x0000 after 256 samples.
- POFF_1=0x80000000 with FTW_1=0, commit -> phase_out_1 = 0x8000 constant; other channels unaffected.
- Change FTW_0 shadow to 0x02000000 without commit -> step remains 0x0100; after commit the step becomes 0x0200 from the second sample after the update.
- Read 0x30 and write 0x40 (NUM_CH=4) -> RRESP/BRESP = SLVERR, RDATA = 0, no register changes; a subsequent valid access completes normally.
- Pulse ARESETN low during a pending BVALID -> bvalid = 0, phase_out = 0 and registers read 0 after release.

Source files
------------

// File: rtl/dds_phase_bank_axil.sv
// rtl/dds_phase_bank_axil.sv - multi-channel DDS phase bank with AXI4-Lite shadow/commit registers
// Optional DDS_DITHER_EN adds a shared 16-bit LFSR dither ahead of phase truncation.
module dds_phase_bank_axil #(
  parameter int NUM_CH             = 4,
  parameter int ACC_W              = 32,
  parameter int OUT_W              = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic                          sample_en,
  output logic [NUM_CH*OUT_W-1:0]       phase_out,
  output logic                          phase_valid
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = ACC_W - OUT_W;

  logic             awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;
  logic             enable_q, commit_pend_q, clr_pend_q, phase_valid_q;
  logic [ACC_W-1:0] ftw_sh_q  [NUM_CH];
  logic [ACC_W-1:0] poff_sh_q [NUM_CH];
  logic [ACC_W-1:0] ftw_q     [NUM_CH];
  logic [ACC_W-1:0] poff_q    [NUM_CH];
  logic [ACC_W-1:0] acc_q     [NUM_CH];
  logic [OUT_W-1:0] phase_q   [NUM_CH];
  logic [OUT_W-1:0] phase_d   [NUM_CH];

  int          wa, ra;
  logic        wr_fire, rd_fire, w_mapped, r_mapped, dither_flag;
  logic [31:0] wmask, rd_word;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign wr_fire = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire = arready_q & s_axi_arvalid;

  function automatic logic [ACC_W-1:0] merge(input logic [ACC_W-1:0] old,
                                             input logic [31:0] wd, input logic [31:0] m);
    logic [31:0] o32;
    o32 = 32'(old);
    return ACC_W'((o32 & ~m) | (wd & m));
  endfunction

`ifdef DDS_DITHER_EN
  logic [15:0]      lfsr_q;
  logic [ACC_W-1:0] dith [NUM_CH];
  assign dither_flag = 1'b1;

  always_comb begin : dither_gen
    logic [15:0] rot;
    for (int k = 0; k < NUM_CH; k++) begin
      rot = 16'((32'(lfsr_q) << k) | (32'(lfsr_q) >> (16 - k)));
      dith[k] = '0;
      for (int b = 0; b < ACC_W; b++)
        if (b < DW && b < 16) dith[k][b] = rot[b % 16];
    end
  end

  // Galois form, taps 16,14,13,11; steps once per delivered sample.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lfsr_q <= 16'hACE1;
    else if (phase_valid_q) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_comb
    for (int k = 0; k < NUM_CH; k++)
      phase_d[k] = OUT_W'((acc_q[k] + poff_q[k] + dith[k]) >> DW);
`else
  assign dither_flag = 1'b0;

  always_comb
    for (int k = 0; k < NUM_CH; k++)
      phase_d[k] = OUT_W'((acc_q[k] + poff_q[k]) >> DW);
`endif

  always_comb begin
    wa       = int'(s_axi_awaddr[AW-1:2]);
    ra       = int'(s_axi_araddr[AW-1:2]);
    wmask    = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
    w_mapped = (wa == 0) || (wa == 1) || (wa >= 4 && wa < 4 + 2 * NUM_CH);
    r_mapped = (ra == 0) || (ra == 1) || (ra >= 4 && ra < 4 + 2 * NUM_CH);
    rd_word  = '0;
    if (ra == 0) rd_word = {31'b0, enable_q};
    if (ra == 1) rd_word = {20'b0, 4'(NUM_CH), 6'b0, dither_flag, commit_pend_q};
    for (int k = 0; k < NUM_CH; k++) begin
      if (ra == 4 + 2 * k) rd_word = 32'(ftw_sh_q[k]);
      if (ra == 5 + 2 * k) rd_word = 32'(poff_sh_q[k]);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      if (!awready_q && !bvalid_q && s_axi_awvalid && s_axi_wvalid) begin
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_mapped ? 2'b00 : 2'b10;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
        bresp_q  <= 2'b00;
      end
      arready_q <= !arready_q && !rvalid_q && s_axi_arvalid;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= r_mapped ? rd_word : 32'h0;
        rresp_q  <= r_mapped ? 2'b00 : 2'b10;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      enable_q      <= 1'b0;
      commit_pend_q <= 1'b0;
      clr_pend_q    <= 1'b0;
      phase_valid_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        ftw_sh_q[k]  <= '0;
        poff_sh_q[k] <= '0;
        ftw_q[k]     <= '0;
        poff_q[k]    <= '0;
        acc_q[k]     <= '0;
        phase_q[k]   <= '0;
      end
    end else begin
      clr_pend_q    <= 1'b0;
      phase_valid_q <= enable_q & sample_en;
      if (commit_pend_q) begin
        commit_pend_q <= 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          ftw_q[k]  <= ftw_sh_q[k];
          poff_q[k] <= poff_sh_q[k];
        end
      end
      if (wr_fire && wa == 0 && s_axi_wstrb[0]) begin
        enable_q <= s_axi_wdata[0];
        if (s_axi_wdata[1]) commit_pend_q <= 1'b1;
        clr_pend_q <= s_axi_wdata[2];
      end
      // Accumulators advance with the active FTW from before any same-edge commit.
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_fire && wa == 4 + 2 * k) ftw_sh_q[k]  <= merge(ftw_sh_q[k], s_axi_wdata, wmask);
        if (wr_fire && wa == 5 + 2 * k) poff_sh_q[k] <= merge(poff_sh_q[k], s_axi_wdata, wmask);
        if (clr_pend_q) acc_q[k] <= '0;
        else if (enable_q && sample_en) acc_q[k] <= acc_q[k] + ftw_q[k];
        if (enable_q && sample_en) phase_q[k] <= phase_d[k];
      end
    end
  end

  always_comb begin
    phase_out = '0;
    for (int k = 0; k < NUM_CH; k++) phase_out[k*OUT_W +: OUT_W] = phase_q[k];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign phase_valid   = phase_valid_q;

endmodule
